// File: rtl/adc_log_pkg.sv
// Shared FSM state type, parameter defaults and sizing helper for the ADC sample logger.
package adc_log_pkg;

  localparam int DEF_DATA_W   = 12;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CH_W     = 5;
  localparam int DEF_AVG_LOG2 = 3;
  localparam int DEF_DEPTH    = 256;
  localparam int DEF_LED_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } log_state_e;

  // A channel index needs at least one bit even when only one channel exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_ch_avg.sv
// Per-channel boxcar averager: sums 2^AVG_LOG2 accepted samples and emits their truncated mean.
module adc_ch_avg
  import adc_log_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] res_o
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum;

  // Disabling the channel throws away any partial average so it can never be written.
  always_comb begin
    sum         = acc_q + ACC_W'(sample_i);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_valid_o = 1'b0;
    if (clear_i || !en_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (valid_i) begin
      if (cnt_q == CNT_LAST) begin
        acc_d       = '0;
        cnt_d       = '0;
        res_valid_o = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign res_o = DATA_W'(sum >> AVG_LOG2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_sample_logger.sv
// Averages per-channel ADC samples and streams {channel, mean} records into a log RAM,
// either circularly or stopping when the RAM is full.
module adc_sample_logger
  import adc_log_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CH_W     = DEF_CH_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LED_W    = DEF_LED_W,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int CI_W    = idx_width(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adc_valid,
  input  logic [CH_W-1:0]        adc_channel,
  input  logic [DATA_W-1:0]      adc_data,
  input  logic [NUM_CH-1:0]      ch_en,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   wrap_en,
  input  logic [CI_W-1:0]        led_sel,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [CI_W+DATA_W-1:0] ram_wdata,
  output logic                   ram_wren,
  output logic [LED_W-1:0]       led_dout,
  output logic                   busy,
  output logic                   full,
  output logic                   wrapped
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  log_state_e state_q, state_d;

  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [CI_W+DATA_W-1:0] wdata_q, wdata_d;
  logic                   pend_q, pend_d;
  logic                   wrapped_q, wrapped_d;
  logic [LED_W-1:0]       led_q, led_d;
  logic [DATA_W-1:0]      last_q [NUM_CH];
  logic [DATA_W-1:0]      last_d [NUM_CH];

  logic                   run_ok;
  logic                   wr_fire;
  logic [NUM_CH-1:0]      ch_hit;
  logic [NUM_CH-1:0]      res_valid;
  logic [DATA_W-1:0]      res [NUM_CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (wr_fire && (addr_q == ADDR_LAST) && !wrap_en) state_d = ST_FULL;
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A write registered last cycle is dropped if we are no longer running or clear arrives now.
  always_comb begin
    busy    = (state_q == ST_RUN);
    full    = (state_q == ST_FULL);
    run_ok  = (state_q == ST_RUN) && !clear;
    wr_fire = pend_q && run_ok;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = run_ok && adc_valid && (int'(adc_channel) == i) && ch_en[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    adc_ch_avg #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
      .clk_i       (clk),
      .rst_ni      (rst),
      .clear_i     (clear),
      .en_i        (ch_en[g]),
      .valid_i     (ch_hit[g]),
      .sample_i    (adc_data),
      .res_valid_o (res_valid[g]),
      .res_o       (res[g])
    );
  end

  // Only one sample arrives per cycle, so at most one channel can complete an average.
  always_comb begin
    pend_d  = 1'b0;
    wdata_d = wdata_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (res_valid[i]) begin
        pend_d  = 1'b1;
        wdata_d = {CI_W'(i), res[i]};
      end
    end
  end

  always_comb begin
    addr_d    = addr_q;
    wrapped_d = wrapped_q;
    if (clear) begin
      addr_d    = '0;
      wrapped_d = 1'b0;
    end else if (wr_fire) begin
      if (addr_q == ADDR_LAST) begin
        if (wrap_en) begin
          addr_d    = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // The LED view follows the last-result table including the write landing this cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      last_d[i] = last_q[i];
      if (wr_fire && (int'(wdata_q[CI_W+DATA_W-1:DATA_W]) == i)) begin
        last_d[i] = wdata_q[DATA_W-1:0];
      end
    end
    led_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(led_sel) == i) begin
        led_d = last_d[i][DATA_W-1 -: LED_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      pend_q    <= 1'b0;
      wrapped_q <= 1'b0;
      led_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        last_q[i] <= '0;
      end
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pend_q    <= pend_d;
      wrapped_q <= wrapped_d;
      led_q     <= led_d;
      for (int i = 0; i < NUM_CH; i++) begin
        last_q[i] <= last_d[i];
      end
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_wren  = wr_fire;
  assign led_dout  = led_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_adc_sample_logger.sv
// Self-checking bench for adc_sample_logger: a behavioural averaging/logging model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_adc_sample_logger;

  localparam int DATA_W   = 12;
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 5;
  localparam int AVG_LOG2 = 3;
  localparam int DEPTH    = 4;
  localparam int LED_W    = 8;
  localparam int ADDR_W   = 2;
  localparam int CI_W     = 2;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   adc_valid = 1'b0;
  logic [CH_W-1:0]        adc_channel = '0;
  logic [DATA_W-1:0]      adc_data = '0;
  logic [NUM_CH-1:0]      ch_en = '0;
  logic                   start = 1'b0;
  logic                   clear = 1'b0;
  logic                   wrap_en = 1'b0;
  logic [CI_W-1:0]        led_sel = '0;
  logic [ADDR_W-1:0]      ram_addr;
  logic [CI_W+DATA_W-1:0] ram_wdata;
  logic                   ram_wren;
  logic [LED_W-1:0]       led_dout;
  logic                   busy;
  logic                   full;
  logic                   wrapped;

  int checks = 0;
  int errors = 0;

  int log_addr[$];
  int log_data[$];

  // Model: 0 = idle, 1 = running, 2 = full
  int m_state = 0;
  int m_addr = 0;
  bit m_wrapped = 1'b0;
  bit m_pend = 1'b0;
  int m_pend_ch = 0;
  int m_pend_val = 0;
  int m_led = 0;
  int m_sum  [NUM_CH];
  int m_cnt  [NUM_CH];
  int m_last [NUM_CH];

  adc_sample_logger #(
    .DATA_W   (DATA_W),
    .NUM_CH   (NUM_CH),
    .CH_W     (CH_W),
    .AVG_LOG2 (AVG_LOG2),
    .DEPTH    (DEPTH),
    .LED_W    (LED_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .adc_valid   (adc_valid),
    .adc_channel (adc_channel),
    .adc_data    (adc_data),
    .ch_en       (ch_en),
    .start       (start),
    .clear       (clear),
    .wrap_en     (wrap_en),
    .led_sel     (led_sel),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_wren    (ram_wren),
    .led_dout    (led_dout),
    .busy        (busy),
    .full        (full),
    .wrapped     (wrapped)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int ch, input int d,
                               input logic st, input logic clr);
    @(negedge clk);
    adc_valid   = v;
    adc_channel = CH_W'(ch);
    adc_data    = DATA_W'(d);
    start       = st;
    clear       = clr;
  endtask

  // Behavioural model: averages are plain sums divided by the sample count.
  always @(posedge clk or negedge rst) begin : model_step
    int  old_state;
    bit  fire;
    int  c;
    if (!rst) begin
      m_state = 0; m_addr = 0; m_wrapped = 0; m_pend = 0;
      m_pend_ch = 0; m_pend_val = 0; m_led = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_sum[i] = 0; m_cnt[i] = 0; m_last[i] = 0;
      end
    end else begin
      old_state = m_state;
      fire = m_pend && (old_state == 1) && !clear;
      if (fire) m_last[m_pend_ch] = m_pend_val;
      m_led = m_last[int'(led_sel)] / (1 << (DATA_W - LED_W));
      if (clear) m_state = 0;
      else if (old_state == 0 && start) m_state = 1;
      else if (old_state == 1 && fire && m_addr == DEPTH - 1 && !wrap_en) m_state = 2;
      if (clear) begin
        m_addr = 0;
        m_wrapped = 0;
      end else if (fire) begin
        if (m_addr == DEPTH - 1) begin
          if (wrap_en) begin
            m_addr = 0;
            m_wrapped = 1;
          end
        end else begin
          m_addr = m_addr + 1;
        end
      end
      m_pend = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear || !ch_en[i]) begin
          m_sum[i] = 0;
          m_cnt[i] = 0;
        end
      end
      c = int'(adc_channel);
      if (old_state == 1 && !clear && adc_valid && c < NUM_CH) begin
        if (ch_en[c]) begin
          m_sum[c] = m_sum[c] + int'(adc_data);
          m_cnt[c] = m_cnt[c] + 1;
          if (m_cnt[c] == NAVG) begin
            m_pend     = 1;
            m_pend_ch  = c;
            m_pend_val = m_sum[c] / NAVG;
            m_sum[c]   = 0;
            m_cnt[c]   = 0;
          end
        end
      end
    end
  end

  // Outputs are compared just after inputs settle for the coming edge.
  always @(negedge clk) begin
    bit exp_wren;
    #1;
    exp_wren = m_pend && (m_state == 1) && !clear;
    checkOutput("ram_wren", ram_wren, exp_wren);
    if (exp_wren && ram_wren) begin
      checkOutput("ram_wdata", ram_wdata, (m_pend_ch << DATA_W) | m_pend_val);
    end
    if (m_state != 2) checkOutput("ram_addr", ram_addr, m_addr);
    checkOutput("busy", busy, m_state == 1);
    checkOutput("full", full, m_state == 2);
    checkOutput("wrapped", wrapped, m_wrapped);
    checkOutput("led_dout", led_dout, m_led);
    if (ram_wren) begin
      log_addr.push_back(int'(ram_addr));
      log_data.push_back(int'(ram_wdata));
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_wren", ram_wren, 0);
    checkOutput("reset_addr", ram_addr, 0);
    checkOutput("reset_wdata", ram_wdata, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_led", led_dout, 0);
    @(negedge clk) rst = 1'b1;

    // Eight samples 100..107 on channel 0 average to 103.
    ch_en = 4'b0001; wrap_en = 1'b0; led_sel = '0;
    log_addr.delete(); log_data.delete();
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 100 + i, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("avg_count", log_data.size(), 1);
    if (log_data.size() >= 1) begin
      checkOutput("avg_addr", log_addr[0], 0);
      checkOutput("avg_data", log_data[0], 103);
    end
    checkOutput("avg_busy", busy, 1);
    checkOutput("avg_led", led_dout, 6);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("clear_addr", ram_addr, 0);
    checkOutput("clear_busy", busy, 0);

    // Full-scale and zero channels interleaved, with stray samples that must be dropped.
    ch_en = 4'b0011;
    log_addr.delete(); log_data.delete();
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 5, 1234, 0, 0);
    applyStimulus(1, 2, 999, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, i % 2, (i % 2 == 0) ? 4095 : 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("alt_count", log_data.size(), 2);
    if (log_data.size() >= 2) begin
      checkOutput("alt_data0", log_data[0], 4095);
      checkOutput("alt_addr0", log_addr[0], 0);
      checkOutput("alt_data1", log_data[1], 4096);
      checkOutput("alt_addr1", log_addr[1], 1);
    end
    checkOutput("alt_led0", led_dout, 255);
    led_sel = 2'd1;
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("alt_led1", led_dout, 0);
    led_sel = '0;
    applyStimulus(0, 0, 0, 0, 1);

    // Five results into a four-entry log without wrapping.
    ch_en = 4'b0001; wrap_en = 1'b0;
    log_addr.delete(); log_data.delete();
    applyStimulus(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, (k + 1) * 100, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("stop_count", log_data.size(), 4);
    if (log_data.size() >= 4) begin
      checkOutput("stop_addr3", log_addr[3], 3);
      checkOutput("stop_data3", log_data[3], 400);
    end
    checkOutput("stop_full", full, 1);
    checkOutput("stop_busy", busy, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("stop_clear_full", full, 0);

    // Five results with wrapping enabled.
    wrap_en = 1'b1;
    log_addr.delete(); log_data.delete();
    applyStimulus(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, (k + 1) * 100, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("wrap_count", log_data.size(), 5);
    if (log_data.size() >= 5) begin
      checkOutput("wrap_addr4", log_addr[4], 0);
      checkOutput("wrap_data4", log_data[4], 500);
    end
    checkOutput("wrap_flag", wrapped, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("wrap_clear_flag", wrapped, 0);

    // Clear arriving the cycle after the eighth sample discards the pending write.
    wrap_en = 1'b0;
    log_addr.delete(); log_data.delete();
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 300, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("abort_count", log_data.size(), 0);
    checkOutput("abort_addr", ram_addr, 0);
    checkOutput("abort_busy", busy, 0);

    // Disabling a channel discards its partial sum.
    log_addr.delete(); log_data.delete();
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 4000, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    ch_en = 4'b0000;
    applyStimulus(0, 0, 0, 0, 0);
    ch_en = 4'b0001;
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 40, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("disable_count", log_data.size(), 1);
    if (log_data.size() >= 1) checkOutput("disable_data", log_data[0], 40);

    // Asynchronous reset mid-run with five samples accumulated.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 7, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_addr", ram_addr, 0);
    checkOutput("rst_wdata", ram_wdata, 0);
    checkOutput("rst_wren", ram_wren, 0);
    checkOutput("rst_led", led_dout, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b1;
    log_addr.delete(); log_data.delete();
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 50, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("post_rst_count", log_data.size(), 1);
    if (log_data.size() >= 1) begin
      checkOutput("post_rst_addr", log_addr[0], 0);
      checkOutput("post_rst_data", log_data[0], 50);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
